latch_exerciser: RTL and testbench

- Synthesizable driver/checker for a level-sensitive D latch under test (LUT).
- Drives the latch's D and enable inputs through a fixed 8-step sequence.
- Samples the latch's Q/Qn outputs and compares them against an internal reference model. Reports an error count and pass/done status.
- Sits beside a d_latch instance on-chip, or on an FPGA board as a hardware self-test.

---
 rtl/latch_exerciser.sv | 184 ++++++++++++++++++
 tb/tb_latch_exerciser.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/latch_exerciser.sv
// Drives a level-sensitive D latch through a fixed 8-step D/enable sequence and
// checks its synchronized Q/Qn against a reference model. Optional error log: LATCH_EXERCISER_ERRLOG_EN.
module latch_exerciser #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             q_in,
    input  logic             qn_in,
    output logic             d_out,
    output logic             en_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       step,
    output logic [1:0]       state_dbg
`ifdef LATCH_EXERCISER_ERRLOG_EN
    ,
    output logic [2:0]       first_fail_step,
    output logic             first_fail_q,
    output logic             first_fail_qn,
    output logic             first_fail_vld
`endif
);

    localparam int CYC_W = $clog2(SETTLE_CYCLES);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Step table, returned as {d, en}.
    function automatic logic [1:0] step_de(input logic [2:0] s);
        logic [1:0] de;
        de = 2'b00;
        case (s)
            3'd0: de = 2'b01;
            3'd1: de = 2'b00;
            3'd2: de = 2'b10;
            3'd3: de = 2'b11;
            3'd4: de = 2'b01;
            3'd5: de = 2'b00;
            3'd6: de = 2'b10;
            3'd7: de = 2'b11;
            default: de = 2'b00;
        endcase
        return de;
    endfunction

    state_t           state, state_n;
    logic [CYC_W-1:0] cycle, cycle_n;
    logic [2:0]       step_n;
    logic             d_n, en_n;
    logic             model, model_n;
    logic [ERR_W-1:0] err_n;
    logic             q_s1, q_s, qn_s1, qn_s;
    logic             sample, mismatch;
    logic [1:0]       de_n;
    logic [2:0]       ff_step, ff_step_n;
    logic             ff_q, ff_q_n, ff_qn, ff_qn_n, ff_vld, ff_vld_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cycle     <= '0;
            step      <= '0;
            d_out     <= 1'b0;
            en_out    <= 1'b0;
            model     <= 1'b0;
            err_count <= '0;
            q_s1      <= 1'b0;
            q_s       <= 1'b0;
            qn_s1     <= 1'b0;
            qn_s      <= 1'b0;
            ff_step   <= '0;
            ff_q      <= 1'b0;
            ff_qn     <= 1'b0;
            ff_vld    <= 1'b0;
        end else begin
            state     <= state_n;
            cycle     <= cycle_n;
            step      <= step_n;
            d_out     <= d_n;
            en_out    <= en_n;
            model     <= model_n;
            err_count <= err_n;
            q_s1      <= q_in;
            q_s       <= q_s1;
            qn_s1     <= qn_in;
            qn_s      <= qn_s1;
            ff_step   <= ff_step_n;
            ff_q      <= ff_q_n;
            ff_qn     <= ff_qn_n;
            ff_vld    <= ff_vld_n;
        end
    end

    always_comb begin
        state_n   = state;
        cycle_n   = cycle;
        step_n    = step;
        d_n       = d_out;
        en_n      = en_out;
        model_n   = model;
        err_n     = err_count;
        ff_step_n = ff_step;
        ff_q_n    = ff_q;
        ff_qn_n   = ff_qn;
        ff_vld_n  = ff_vld;
        de_n      = 2'b00;
        sample    = (state == S_DRIVE) && (cycle == LAST_CYC);
        mismatch  = (q_s != model) || (qn_s != ~q_s);

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    de_n      = step_de(3'd0);
                    state_n   = S_DRIVE;
                    step_n    = 3'd0;
                    cycle_n   = '0;
                    d_n       = de_n[1];
                    en_n      = de_n[0];
                    err_n     = '0;
                    ff_step_n = '0;
                    ff_q_n    = 1'b0;
                    ff_qn_n   = 1'b0;
                    ff_vld_n  = 1'b0;
                    // Model tracks the step being driven, so it updates on the load edge.
                    if (de_n[0]) model_n = de_n[1];
                end
            end
            S_DRIVE: begin
                cycle_n = cycle + 1'b1;
                if (sample) begin
                    if (mismatch) begin
                        if (err_count != {ERR_W{1'b1}}) err_n = err_count + 1'b1;
                        if (!ff_vld) begin
                            ff_step_n = step;
                            ff_q_n    = q_s;
                            ff_qn_n   = qn_s;
                            ff_vld_n  = 1'b1;
                        end
                    end
                    if (step != 3'd7) begin
                        de_n    = step_de(step + 3'd1);
                        step_n  = step + 3'd1;
                        cycle_n = '0;
                        d_n     = de_n[1];
                        en_n    = de_n[0];
                        if (de_n[0]) model_n = de_n[1];
                    end else begin
                        // Leave the latch holding with enable low.
                        state_n = S_DONE;
                        d_n     = 1'b0;
                        en_n    = 1'b0;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy      = (state == S_DRIVE);
    assign done      = (state == S_DONE);
    assign pass      = done && (err_count == '0);
    assign state_dbg = state;

`ifdef LATCH_EXERCISER_ERRLOG_EN
    assign first_fail_step = ff_step;
    assign first_fail_q    = ff_q;
    assign first_fail_qn   = ff_qn;
    assign first_fail_vld  = ff_vld;
`else
    logic unused_ff;
    assign unused_ff = ^{ff_step, ff_q, ff_qn, ff_vld};
`endif

endmodule

// File: tb/tb_latch_exerciser.sv
// Bench for latch_exerciser: behavioural D latch with selectable faults, table-driven
// runs plus hand sequences for abort, ignored start, restart and reset/start collision.
module tb_latch_exerciser;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       q_in, qn_in;
    logic       d_out, en_out, busy, done, pass;
    logic [3:0] err_count;
    logic [2:0] step;
    logic [1:0] state_dbg;
    logic       d3, en3, busy3, done3, pass3;
    logic [2:0] err3, step3;
    logic [1:0] state3;
`ifdef LATCH_EXERCISER_ERRLOG_EN
    logic [2:0] ff_step, ff_step3;
    logic       ff_q, ff_qn, ff_vld, ff_q3, ff_qn3, ff_vld3;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int mode = 0;  // 0 ideal, 1 q stuck 0, 2 qn tied to q, 3 enable ignored
    logic lat_q = 1'b0;
    logic [1:0] exp_q[$];  // expected {d_out, en_out} per step
    logic exp_d  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic exp_en [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    latch_exerciser #(.SETTLE_CYCLES(4), .ERR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .q_in(q_in), .qn_in(qn_in),
        .d_out(d_out), .en_out(en_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .step(step), .state_dbg(state_dbg)
`ifdef LATCH_EXERCISER_ERRLOG_EN
        , .first_fail_step(ff_step), .first_fail_q(ff_q), .first_fail_qn(ff_qn),
        .first_fail_vld(ff_vld)
`endif
    );

    latch_exerciser #(.SETTLE_CYCLES(4), .ERR_W(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .q_in(q_in), .qn_in(qn_in),
        .d_out(d3), .en_out(en3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .step(step3), .state_dbg(state3)
`ifdef LATCH_EXERCISER_ERRLOG_EN
        , .first_fail_step(ff_step3), .first_fail_q(ff_q3), .first_fail_qn(ff_qn3),
        .first_fail_vld(ff_vld3)
`endif
    );

    // Behavioural latch under test with fault injection.
    always @(d_out, en_out) if (en_out) lat_q = d_out;

    logic q_v;
    always_comb begin
        case (mode)
            1:       q_v = 1'b0;
            3:       q_v = d_out;
            default: q_v = lat_q;
        endcase
        q_in  = q_v;
        qn_in = (mode == 2) ? q_v : ~q_v;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // One full run; checks the driven sequence via the expected queue and the run length.
    task automatic do_run();
        int cyc;
        logic [1:0] e;
        for (int s = 0; s < 8; s++) exp_q.push_back({exp_d[s], exp_en[s]});
        pulse_start();
        check("restart_done_low", {31'd0, done}, 0);
        check("restart_err_clear", {28'd0, err_count}, 0);
        cyc = 0;
        while (busy && cyc < 100) begin
            if (cyc % 4 == 0) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
                check("step_idx", {29'd0, step}, cyc / 4);
                check("d_en", {30'd0, d_out, en_out}, {30'd0, e});
            end
            cyc++;
            @(negedge clk);
        end
        check("busy_len", cyc, 32);
        check("exp_q_empty", exp_q.size(), 0);
        exp_q.delete();
        check("done", {31'd0, done}, 1);
        check("done_en_low", {31'd0, en_out}, 0);
    endtask

    typedef struct {
        int         mode;
        int         err;
        logic       pass;
        int         err3;
        logic [2:0] ff_step;
        logic       ff_q;
        logic       ff_qn;
        logic       ff_vld;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cyc;
        logic injected;
        vecs[0] = '{0, 0, 1'b1, 0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1, 2, 1'b0, 2, 3'd3, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{2, 8, 1'b0, 7, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{3, 2, 1'b0, 2, 3'd2, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{0, 0, 1'b1, 0, 3'd0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_d_en", {30'd0, d_out, en_out}, 0);
        check("rst_step", {29'd0, step}, 0);
        check("rst_err", {28'd0, err_count}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            mode = vecs[i].mode;
            do_run();
            check($sformatf("v%0d_err", i), {28'd0, err_count}, vecs[i].err);
            check($sformatf("v%0d_pass", i), {31'd0, pass}, {31'd0, vecs[i].pass});
            check($sformatf("v%0d_err3", i), {29'd0, err3}, vecs[i].err3);
`ifdef LATCH_EXERCISER_ERRLOG_EN
            check($sformatf("v%0d_ff_vld", i), {31'd0, ff_vld}, {31'd0, vecs[i].ff_vld});
            check($sformatf("v%0d_ff_step", i), {29'd0, ff_step}, {29'd0, vecs[i].ff_step});
            check($sformatf("v%0d_ff_q", i), {30'd0, ff_q, ff_qn},
                  {30'd0, vecs[i].ff_q, vecs[i].ff_qn});
`endif
        end

        // Abort in step 4 after one failure has been counted.
        mode = 1;
        pulse_start();
        cyc = 0;
        while (step != 3'd4 && cyc < 100) begin cyc++; @(negedge clk); end
        check("reach_step4", {31'd0, cyc < 100}, 1);
        check("pre_abort_err", {28'd0, err_count}, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_en", {31'd0, en_out}, 0);
        check("abort_step", {29'd0, step}, 0);
        check("abort_err", {28'd0, err_count}, 0);
        check("abort_done", {31'd0, done}, 0);
        rst = 1'b0;
        mode = 0;
        do_run();
        check("post_abort_pass", {31'd0, pass}, 1);

        // start during step 5 must not disturb the run.
        pulse_start();
        cyc = 0;
        injected = 1'b0;
        while (busy && cyc < 100) begin
            if (step == 3'd5 && !injected) begin start = 1'b1; injected = 1'b1; end
            else start = 1'b0;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check("ignore_start_len", cyc, 32);
        check("ignore_start_pass", {31'd0, pass}, 1);
        check("ignore_start_step", {29'd0, step}, 7);

        // rst and start together in DONE: rst wins, no run begins.
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        check("collide_busy", {31'd0, busy}, 0);
        check("collide_done", {31'd0, done}, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("collide_idle", {31'd0, busy}, 0);
        check("collide_step", {29'd0, step}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
